// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: load encodings, FSM states, datapath width.
package wb_stage_pkg;

  localparam int XLEN = 32;

  // funct3 encodings of the supported integer loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_WRITE     = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_formatter.sv
// Combinational load data extraction: picks the addressed byte/half/word out of the
// aligned LSU word and sign- or zero-extends it. Flags misaligned and unknown loads.
module load_formatter
  import wb_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] wdata,
  output logic            misalign,
  output logic            bad_fn
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection; a misaligned half still uses only addr_lo[1]
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by load type; unknown encodings fall back to a full word
  always_comb begin
    wdata    = rdata;
    misalign = 1'b0;
    bad_fn   = 1'b0;
    case (funct3)
      F3_LB:  wdata = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: wdata = {24'h0, byte_sel};
      F3_LH: begin
        wdata    = {{16{half_sel[15]}}, half_sel};
        misalign = addr_lo[0];
      end
      F3_LHU: begin
        wdata    = {16'h0, half_sel};
        misalign = addr_lo[0];
      end
      F3_LW: begin
        wdata    = rdata;
        misalign = (addr_lo != 2'd0);
      end
      default: begin
        wdata  = rdata;
        bad_fn = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts execute results (valid/ready), waits for load data when
// needed, and drives exactly one registered register-file write per retired instruction.
//
// Handshake: a transfer happens on a rising edge where exu_valid && exu_ready; exu_*
// is sampled only then. exu_ready depends on state alone (low only in WAIT_LOAD), so it
// never combinationally depends on exu_valid.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  exu_is_load,
  input  logic [2:0]            exu_funct3,
  input  logic [1:0]            exu_addr_lo,
  input  logic                  lsu_rvalid,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  retire,
  output logic                  err,
  output wb_state_e             dbg_state
);

  if (DATA_WIDTH != XLEN) begin : g_bad_width
    $error("wb_stage: only DATA_WIDTH=32 is supported");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_stage: TIMEOUT must be in 1..65535");
  end

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  wb_state_e             state, state_n;
  logic [15:0]           cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] ld_rd;
  logic [2:0]            ld_f3;
  logic [1:0]            ld_lo;
  logic                  xfer;
  logic                  ld_latch;
  logic                  wr_go;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  err_set;
  logic [DATA_WIDTH-1:0] fmt_wdata;
  logic                  fmt_misalign;
  logic                  fmt_bad_fn;

  load_formatter u_fmt (
    .rdata    (lsu_rdata),
    .funct3   (ld_f3),
    .addr_lo  (ld_lo),
    .wdata    (fmt_wdata),
    .misalign (fmt_misalign),
    .bad_fn   (fmt_bad_fn)
  );

  assign exu_ready = (state != ST_WAIT_LOAD);
  assign xfer      = exu_valid && exu_ready;
  assign dbg_state = state;

  // Next state, pending write and error detection
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ld_latch = 1'b0;
    wr_go    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    err_set  = 1'b0;
    case (state)
      ST_IDLE, ST_WRITE: begin
        // WRITE behaves like IDLE so back-to-back results retire one per cycle
        state_n = ST_IDLE;
        err_set = lsu_rvalid;
        if (xfer) begin
          if (exu_is_load) begin
            state_n  = ST_WAIT_LOAD;
            cnt_n    = '0;
            ld_latch = 1'b1;
          end else begin
            state_n = ST_WRITE;
            wr_go   = 1'b1;
            wr_addr = exu_rd;
            wr_data = exu_data;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (lsu_rvalid) begin
          state_n = ST_WRITE;
          wr_go   = 1'b1;
          wr_addr = ld_rd;
          wr_data = fmt_wdata;
          err_set = fmt_misalign | fmt_bad_fn;
        end else if (cnt == CNT_LAST) begin
          // Give up on the LSU: retire with zero data and flag it
          state_n = ST_WRITE;
          wr_go   = 1'b1;
          wr_addr = ld_rd;
          wr_data = '0;
          err_set = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, load context, registered write port and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ld_rd    <= '0;
      ld_f3    <= '0;
      ld_lo    <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      retire   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      if (ld_latch) begin
        ld_rd <= exu_rd;
        ld_f3 <= exu_funct3;
        ld_lo <= exu_addr_lo;
      end
      rf_wen   <= wr_go && (wr_addr != '0);
      rf_waddr <= wr_addr;
      rf_wdata <= wr_data;
      retire   <= wr_go;
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with an expected-write queue and an independent monitor.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int EW = 1 + AW + DW;

  logic          clk;
  logic          rst_n;
  logic          exu_valid;
  logic          exu_ready;
  logic [AW-1:0] exu_rd;
  logic [DW-1:0] exu_data;
  logic          exu_is_load;
  logic [2:0]    exu_funct3;
  logic [1:0]    exu_addr_lo;
  logic          lsu_rvalid;
  logic [DW-1:0] lsu_rdata;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          retire;
  logic          err;
  wb_state_e     dbg_state;

  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  wb_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .exu_valid   (exu_valid),
    .exu_ready   (exu_ready),
    .exu_rd      (exu_rd),
    .exu_data    (exu_data),
    .exu_is_load (exu_is_load),
    .exu_funct3  (exu_funct3),
    .exu_addr_lo (exu_addr_lo),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_rdata   (lsu_rdata),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .retire      (retire),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  function automatic logic [EW-1:0] mk_exp(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    return {(rd != 0), rd, d};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (retire) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 64'(retire), 64'(0));
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("wb_write", 64'({rf_wen, rf_waddr, rf_wdata}), 64'(e));
        end
      end else begin
        check("idle_outputs", 64'({rf_wen, rf_waddr, rf_wdata}), 64'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    exu_valid   = 1'b0;
    exu_rd      = '0;
    exu_data    = '0;
    exu_is_load = 1'b0;
    exu_funct3  = '0;
    exu_addr_lo = '0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
  endtask

  // ALU result: accept, then the write must be visible in the next cycle
  task automatic send_alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    exp_q.push_back(mk_exp(rd, d));
    exu_valid = 1'b1; exu_is_load = 1'b0; exu_rd = rd; exu_data = d;
    @(posedge clk);
    @(negedge clk);
    exu_valid = 1'b0;
    check("alu_latency_retire", 64'(retire), 64'(1));
    @(negedge clk);
    check("alu_after_retire", 64'({retire, rf_wen}), 64'(0));
  endtask

  // Load with lsu_rvalid after `delay` wait cycles; expected value given by caller
  task automatic send_load(input logic [AW-1:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [DW-1:0] rdata, input int delay, input logic [DW-1:0] req);
    exp_q.push_back(mk_exp(rd, req));
    exu_valid = 1'b1; exu_is_load = 1'b1; exu_rd = rd; exu_funct3 = f3;
    exu_addr_lo = lo; exu_data = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    exu_valid = 1'b0;
    check("load_ready_low", 64'(exu_ready), 64'(0));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("load_wait_ready", 64'({exu_ready, retire}), 64'(0));
    end
    lsu_rvalid = 1'b1; lsu_rdata = rdata;
    @(posedge clk);
    @(negedge clk);
    lsu_rvalid = 1'b0; lsu_rdata = '0;
    check("load_latency_retire", 64'(retire), 64'(1));
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_outputs", 64'({rf_wen, rf_waddr, rf_wdata, retire, err}), 64'(0));
    check("rst_ready", 64'(exu_ready), 64'(1));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single ALU write
    send_alu(5'd5, 32'hDEAD_BEEF);

    // back-to-back ALU results, middle one to x0
    exp_q.push_back(mk_exp(5'd1, 32'h1111_0001));
    exp_q.push_back(mk_exp(5'd0, 32'h2222_0002));
    exp_q.push_back(mk_exp(5'd2, 32'h3333_0003));
    exu_valid = 1'b1; exu_is_load = 1'b0;
    exu_rd = 5'd1; exu_data = 32'h1111_0001;
    @(posedge clk); @(negedge clk);
    check("b2b_retire0", 64'({retire, rf_wen}), 64'(2'b11));
    exu_rd = 5'd0; exu_data = 32'h2222_0002;
    @(posedge clk); @(negedge clk);
    check("b2b_retire1", 64'({retire, rf_wen}), 64'(2'b10));
    exu_rd = 5'd2; exu_data = 32'h3333_0003;
    @(posedge clk); @(negedge clk);
    check("b2b_retire2", 64'({retire, rf_wen}), 64'(2'b11));
    exu_valid = 1'b0;
    @(negedge clk);
    check("b2b_done", 64'(retire), 64'(0));

    // load extension on 0x80F07F81
    send_load(5'd3, F3_LB,  2'd0, 32'h80F0_7F81, 0, 32'hFFFF_FF81);
    send_load(5'd4, F3_LBU, 2'd3, 32'h80F0_7F81, 0, 32'h0000_0080);
    send_load(5'd6, F3_LH,  2'd2, 32'h80F0_7F81, 0, 32'hFFFF_80F0);
    send_load(5'd7, F3_LHU, 2'd0, 32'h80F0_7F81, 0, 32'h0000_7F81);
    send_load(5'd8, F3_LW,  2'd0, 32'h80F0_7F81, 0, 32'h80F0_7F81);
    send_load(5'd9, F3_LB,  2'd1, 32'h80F0_7F81, 1, 32'h0000_007F);
    send_load(5'd10, F3_LH, 2'd0, 32'h80F0_7F81, 0, 32'h0000_7F81);
    send_load(5'd11, F3_LHU, 2'd2, 32'h80F0_7F81, 0, 32'h0000_80F0);
    send_load(5'd0, F3_LBU, 2'd2, 32'h80F0_7F81, 0, 32'h0000_00F0);
    check("ext_no_err", 64'(err), 64'(0));

    // stalled load, rvalid after 4 wait cycles
    send_load(5'd12, F3_LW, 2'd0, 32'hCAFE_F00D, 4, 32'hCAFE_F00D);
    check("stall_no_err", 64'(err), 64'(0));

    // timeout: no rvalid, write of zero exactly 8 cycles after accept
    exp_q.push_back(mk_exp(5'd13, 32'h0));
    exu_valid = 1'b1; exu_is_load = 1'b1; exu_rd = 5'd13; exu_funct3 = F3_LW;
    exu_addr_lo = 2'd0; exu_data = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    exu_valid = 1'b0;
    for (int k = 1; k < 9; k++) begin
      if (k > 1) @(negedge clk);
      check("timeout_wait", 64'({retire, exu_ready}), 64'(0));
    end
    @(negedge clk);
    check("timeout_retire", 64'(retire), 64'(1));
    check("timeout_err", 64'(err), 64'(1));
    @(negedge clk);

    // async reset in the middle of a load wait
    exu_valid = 1'b1; exu_is_load = 1'b1; exu_rd = 5'd14; exu_funct3 = F3_LW;
    @(posedge clk);
    @(negedge clk);
    exu_valid = 1'b0;
    check("mid_load_ready", 64'(exu_ready), 64'(0));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 64'({rf_wen, rf_waddr, rf_wdata, retire, err}), 64'(0));
    check("async_rst_ready", 64'(exu_ready), 64'(1));
    #2 rst_n = 1'b1;
    @(negedge clk);
    lsu_rvalid = 1'b1; lsu_rdata = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    lsu_rvalid = 1'b0; lsu_rdata = '0;
    check("stray_rvalid_no_write", 64'({retire, rf_wen}), 64'(0));
    check("stray_rvalid_err", 64'(err), 64'(1));

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the integer register file; sole driver of its write port (wen/waddr/wdata).
- Accepts completed instructions from the execute unit over a valid/ready handshake.
- For loads, waits for the LSU read response, then extracts and sign/zero-extends the addressed byte/half/word.
- Issues exactly one registered register-file write per retired instruction; suppresses writes to x0; flags protocol errors and load timeouts.

Parameters:
- ADDR_WIDTH, 5, register index width; must match the register file.
- DATA_WIDTH, 32, datapath width; only 32 supported, enforced by elaboration-time check.
- TIMEOUT, 255, max cycles in WAIT_LOAD before forced completion; range 1..65535.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- exu_valid  in  1  execute result valid
- exu_ready  out  1  stage can accept; combinational from state
- exu_rd  in  ADDR_WIDTH  destination register
- exu_data  in  DATA_WIDTH  ALU result, ignored for loads
- exu_is_load  in  1  instruction is a load
- exu_funct3  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- exu_addr_lo  in  2  load address bits [1:0]
- lsu_rvalid  in  1  one-cycle load data pulse
- lsu_rdata  in  DATA_WIDTH  aligned 32-bit word containing the load
- rf_wen  out  1  register-file write enable, registered
- rf_waddr  out  ADDR_WIDTH  registered
- rf_wdata  out  DATA_WIDTH  registered
- retire  out  1  one-cycle pulse per completed instruction, registered
- err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rf_wen=0, rf_waddr=0, rf_wdata=0, retire=0, err=0, timeout counter=0.
  - exu_ready=1 (decoded from IDLE).
- States: IDLE, WAIT_LOAD, WRITE.
- exu_ready=1 in IDLE and WRITE; exu_ready=0 in WAIT_LOAD.
- Handshake:
  - A transfer occurs when exu_valid && exu_ready at a rising edge.
  - exu_* inputs are sampled only on transfer.
- Non-load accepted:
  - Next state WRITE.
  - In that cycle: retire=1; rf_wen=(rd!=0); rf_waddr=rd; rf_wdata=exu_data.
  - Latency is 1 cycle from accept edge to rf_wen high.
- Load accepted:
  - Latch rd, funct3, addr_lo; clear the counter; go to WAIT_LOAD.
- WAIT_LOAD, on lsu_rvalid (the same edge may be the accept edge only if no lsu_rvalid, see error rules):
  - Format lsu_rdata and go to WRITE.
  - The formatted write appears 1 cycle after the lsu_rvalid edge.
- Load formatting:
  - Byte = lsu_rdata[8*addr_lo +: 8].
  - Half = addr_lo[1] ? rdata[31:16] : rdata[15:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- WAIT_LOAD timeout:
  - Counter increments each cycle without lsu_rvalid.
  - When counter==TIMEOUT-1 and no rvalid: err<=1, WRITE with rf_wdata=0, and retire still pulses.
- WRITE:
  - Lasts exactly one cycle.
  - If a new transfer occurs in the same cycle, it is processed as from IDLE (back-to-back ALU results give one write per cycle).
  - Otherwise next state IDLE.
- rf_wen, rf_waddr, rf_wdata and retire are 0 in every cycle not in WRITE.
- Error conditions (set err, never block):
  - lsu_rvalid outside WAIT_LOAD: pulse ignored.
  - Undefined funct3 on a load: formatted as lw.
  - lh/lhu with addr_lo[0]=1: addr_lo[1] still used.
  - lw with addr_lo!=0: word passed unchanged.
- Reset mid-load: returns to IDLE immediately; no write issued; a late lsu_rvalid after reset sets err.
- rd=0: state sequence and retire unchanged; only rf_wen is suppressed.

Decomposition:
- Shared package:
  - funct3 load encodings (LB, LH, LW, LBU, LHU).
  - State enum encoding.
  - XLEN=32 constant.
- One sub-module: load_formatter.
  - Purely combinational.
  - Inputs: rdata, funct3, addr_lo.
  - Outputs: wdata, misalign, bad_fn.

Test Plan:
- ALU write: accept rd=5, data=0xDEADBEEF → next cycle rf_wen=1, waddr=5, wdata=0xDEADBEEF, retire=1; following cycle all 0.
- Back-to-back plus x0: exu_valid held 3 cycles with rd=1,0,2 → retire high 3 consecutive cycles; rf_wen high for rd 1 and 2 only.
- Load extension: lsu_rdata=0x80F0_7F81.
  - lb addr_lo=0 → 0xFFFFFF81.
  - lbu addr_lo=3 → 0x00000080.
  - lh addr_lo=2 → 0xFFFF80F0.
  - lhu addr_lo=0 → 0x00007F81.
  - lw → 0x80F07F81.
- Load stall: load accepted, lsu_rvalid after 4 cycles → exu_ready=0 during the wait, write 1 cycle after rvalid, err=0.
- Timeout with TIMEOUT=8: load accepted, no rvalid → write of rd with data 0 exactly 8 cycles after accept, err=1.
- Async reset mid-WAIT_LOAD: rst_n low for half a cycle → outputs 0 immediately, exu_ready=1; a subsequent stray lsu_rvalid → no write, err=1.
